mem_bus_arbiter: RTL and testbench

//  Shares one single-port 32-bit memory bus between instruction fetch (IF) and the data

---
 rtl/mem_bus_arbiter_if.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of core-side (fetch + data) and memory-side bus signals for mem_bus_arbiter.
// slave  : the arbiter's view (takes requests and memory responses, drives bus and acks)
// master : the environment's view (core ports plus the memory that answers the bus)
interface mem_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        timeout_err;
  logic        misalign_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           stall, timeout_err, misalign_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           stall, timeout_err, misalign_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 32-bit single-port memory bus between instruction fetch
// and the load/store port. Data has fixed priority over fetch. Each access is a
// req/ack transaction with a watchdog (TIMEOUT_CYC, 0 disables it).
// Optional macro MISALIGN_TRAP_EN: misaligned word/half data accesses are trapped
// without a bus cycle and flagged on misalign_err; otherwise low address bits are ignored.
//
// state  | meaning
// IDLE   | no access outstanding; data request wins over fetch
// GNT_D  | data access on the bus, waiting for mem_ack or watchdog
// GNT_IF | fetch access on the bus, waiting for mem_ack or watchdog
// DONE   | ack pulse cycle; requests ignored so the requester can drop req
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYC = 255
) (
  input logic           clk,
  input logic           rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, GNT_D, GNT_IF, DONE} state_t;

  state_t        state;
  logic [CW-1:0] wd_cnt;
  logic [CW-1:0] wd_next;
  logic          cur_we;
  logic [1:0]    cur_size;
  logic [1:0]    cur_lo;

  logic          mem_req_q, mem_we_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_addr_q, mem_wdata_q;
  logic [31:0]   if_rdata_q, d_rdata_q;
  logic          if_ack_q, d_ack_q, timeout_q;

  logic [3:0]    d_be;
  logic [31:0]   d_wrep;
  logic          misal;

  // Zero-extend the lane of a read word picked by access size and low address bits
  function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] lo,
                                               input logic [31:0] w);
    case (size)
      2'b01:   return lo[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
      2'b10:   return {24'h0, w[{lo, 3'b000} +: 8]};
      default: return w;
    endcase
  endfunction

  assign wd_next = wd_cnt + 1'b1;

  // Byte lanes, replicated store data and misalignment of the pending data request
  always_comb begin
    d_be   = 4'b1111;
    d_wrep = bus.d_wdata;
    misal  = 1'b0;
    case (bus.d_size)
      2'b01: begin
        d_be   = bus.d_addr[1] ? 4'b1100 : 4'b0011;
        d_wrep = {2{bus.d_wdata[15:0]}};
      end
      2'b10: begin
        d_be   = 4'b0001 << bus.d_addr[1:0];
        d_wrep = {4{bus.d_wdata[7:0]}};
      end
      default: ;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (bus.d_size == 2'b01)
      misal = bus.d_addr[0];
    else if (bus.d_size != 2'b10)
      misal = |bus.d_addr[1:0];
`endif
  end

  // Arbitration FSM with registered bus signals, acks, read data and watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wd_cnt      <= '0;
      cur_we      <= 1'b0;
      cur_size    <= 2'b00;
      cur_lo      <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.d_req) begin
            if (misal) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= 32'h0;
              state     <= DONE;
            end else begin
              state       <= GNT_D;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.d_we;
              mem_be_q    <= d_be;
              mem_addr_q  <= {bus.d_addr[31:2], 2'b00};
              mem_wdata_q <= bus.d_we ? d_wrep : 32'h0;
              cur_we      <= bus.d_we;
              cur_size    <= bus.d_size;
              cur_lo      <= bus.d_addr[1:0];
              wd_cnt      <= '0;
            end
          end else if (bus.if_req) begin
            state       <= GNT_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b1111;
            mem_addr_q  <= {bus.if_addr[31:2], 2'b00};
            mem_wdata_q <= 32'h0;
            wd_cnt      <= '0;
          end
        end
        GNT_D, GNT_IF: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state     <= DONE;
            if (state == GNT_D) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= cur_we ? 32'h0 : lane_extract(cur_size, cur_lo, bus.mem_rdata);
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end else begin
            wd_cnt <= wd_next;
            // an ack in the same cycle takes the branch above, so it always beats the abort
            if (TIMEOUT_CYC != 0 && wd_next == TO_LAST) begin
              mem_req_q <= 1'b0;
              timeout_q <= 1'b1;
              state     <= DONE;
              if (state == GNT_D) begin
                d_ack_q   <= 1'b1;
                d_rdata_q <= 32'hDEADBEEF;
              end else begin
                if_ack_q   <= 1'b1;
                if_rdata_q <= 32'hDEADBEEF;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misal_q;

  // Error pulse lines up with the d_ack of a trapped access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misal_q <= 1'b0;
    else     misal_q <= (state == IDLE) && bus.d_req && misal;
  end

  assign bus.misalign_err = misal_q;
`else
  assign bus.misalign_err = 1'b0;
`endif

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_be      = mem_be_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.if_ack      = if_ack_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.d_ack       = d_ack_q;
  assign bus.timeout_err = timeout_q;
  assign bus.stall       = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed cases plus randomized traffic
// checked against an arithmetic reference of lanes, replication and extraction.
module tb_mem_bus_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus();
  mem_bus_arbiter #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int pass_cnt = 0;
  int total_cnt = 0;

  // memory responder: acks after mem_lat extra cycles, logs the bus fields it saw
  int          mem_lat = 0;
  int          wait_cnt = 0;
  logic        mem_en = 1'b1;
  logic        stray_ack = 1'b0;
  logic [31:0] rd_val = 32'h0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  int          bus_txns = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_ack   <= 1'b0;
      bus.mem_rdata <= 32'h0;
      wait_cnt      <= 0;
    end else if (bus.mem_ack) begin
      bus.mem_ack <= 1'b0;
    end else if (stray_ack) begin
      bus.mem_ack <= 1'b1;
    end else if (bus.mem_req && mem_en) begin
      if (wait_cnt >= mem_lat) begin
        bus.mem_ack   <= 1'b1;
        bus.mem_rdata <= rd_val;
        wait_cnt      <= 0;
        cap_addr      <= bus.mem_addr;
        cap_be        <= bus.mem_be;
        cap_we        <= bus.mem_we;
        cap_wdata     <= bus.mem_wdata;
        bus_txns      <= bus_txns + 1;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // bus cycles must be separated by at least the DONE and IDLE cycles
  int low_run = 2;
  int gap_viol = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) low_run = 2;
    else begin
      if (bus.mem_req === 1'b1 && low_run > 0 && low_run < 2) gap_viol++;
      low_run = (bus.mem_req === 1'b1) ? 0 : low_run + 1;
    end
  end

  // reference model
  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (sz == 2'b10) return 4'(1 << off);
    if (sz == 2'b01) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'b10) return {24'h0, w[7:0]} * 32'h01010101;
    if (sz == 2'b01) return {16'h0, w[15:0]} * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] ref_rdata(input logic [1:0] sz, input logic [31:0] a,
                                            input logic [31:0] r, input logic we);
    int off, bits;
    logic [63:0] m;
    if (we) return 32'h0;
    if (sz == 2'b10) begin off = int'(a % 4); bits = 8; end
    else if (sz == 2'b01) begin off = (a % 4 >= 2) ? 2 : 0; bits = 16; end
    else begin off = 0; bits = 32; end
    m = (64'd1 << bits) - 64'd1;
    return 32'(({32'h0, r} >> (8 * off)) & m);
  endfunction

  // drives one data request, waits (bounded) for d_ack, then lets DONE pass
  task automatic data_txn(input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] w, input logic [31:0] rdv, input int lat,
                          output logic [31:0] rd, output int cyc, output int stall_low,
                          output int req_hi, output logic mis, output logic ack2);
    logic got;
    rd_val = rdv; mem_lat = lat;
    bus.d_we = we; bus.d_size = sz; bus.d_addr = a; bus.d_wdata = w; bus.d_req = 1'b1;
    cyc = 0; got = 1'b0; stall_low = 0; req_hi = 0; rd = 32'hx; mis = 1'bx;
    while (!got && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.mem_req === 1'b1) req_hi++;
      if (bus.d_ack === 1'b1) begin got = 1'b1; rd = bus.d_rdata; mis = bus.misalign_err; end
      else if (bus.stall !== 1'b1) stall_low++;
    end
    bus.d_req = 1'b0;
    @(posedge clk); #1;
    ack2 = bus.d_ack;
  endtask

  task automatic fetch_txn(input logic [31:0] a, input logic [31:0] rdv, input int lat,
                           output logic [31:0] rd, output int cyc);
    logic got;
    rd_val = rdv; mem_lat = lat;
    bus.if_addr = a; bus.if_req = 1'b1;
    cyc = 0; got = 1'b0; rd = 32'hx;
    while (!got && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.if_ack === 1'b1) begin got = 1'b1; rd = bus.if_rdata; end
    end
    bus.if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); else pass_cnt++;
    total_cnt++; if (bus.mem_be !== 4'h0) $display("FAIL reset_mem_be got=%h exp=0", bus.mem_be); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); else pass_cnt++;
    total_cnt++; if ({bus.if_ack, bus.d_ack} !== 2'b00) $display("FAIL reset_acks got=%b exp=00", {bus.if_ack, bus.d_ack}); else pass_cnt++;
    total_cnt++; if ({bus.if_rdata, bus.d_rdata} !== 64'h0) $display("FAIL reset_rdata got=%h exp=0", {bus.if_rdata, bus.d_rdata}); else pass_cnt++;
    total_cnt++; if ({bus.timeout_err, bus.misalign_err} !== 2'b00) $display("FAIL reset_errs got=%b exp=00", {bus.timeout_err, bus.misalign_err}); else pass_cnt++;
    total_cnt++; if (bus.stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.stall); else pass_cnt++;
  endtask

  task automatic test_fetch();
    logic [31:0] rd; int cyc;
    fetch_txn(32'h40, 32'h2402000A, 0, rd, cyc);
    total_cnt++; if (cap_be !== 4'hF) $display("FAIL fetch_be got=%h exp=f", cap_be); else pass_cnt++;
    total_cnt++; if (cap_addr !== 32'h40) $display("FAIL fetch_addr got=%h exp=40", cap_addr); else pass_cnt++;
    total_cnt++; if (cap_we !== 1'b0) $display("FAIL fetch_we got=%b exp=0", cap_we); else pass_cnt++;
    total_cnt++; if (cyc !== 3) $display("FAIL fetch_latency got=%0d exp=3", cyc); else pass_cnt++;
    total_cnt++; if (rd !== 32'h2402000A) $display("FAIL fetch_rdata got=%h exp=2402000a", rd); else pass_cnt++;
  endtask

  task automatic test_store_byte();
    logic [31:0] rd; int cyc, sl, rh; logic mis, ack2;
    data_txn(1'b1, 2'b10, 32'h103, 32'h000000A5, 32'h12345678, 0, rd, cyc, sl, rh, mis, ack2);
    total_cnt++; if (cap_be !== 4'b1000) $display("FAIL sb_be got=%b exp=1000", cap_be); else pass_cnt++;
    total_cnt++; if (cap_wdata !== 32'hA5A5A5A5) $display("FAIL sb_wdata got=%h exp=a5a5a5a5", cap_wdata); else pass_cnt++;
    total_cnt++; if (cap_addr !== 32'h100) $display("FAIL sb_addr got=%h exp=100", cap_addr); else pass_cnt++;
    total_cnt++; if (cap_we !== 1'b1) $display("FAIL sb_we got=%b exp=1", cap_we); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0) $display("FAIL sb_rdata got=%h exp=0", rd); else pass_cnt++;
    total_cnt++; if (ack2 !== 1'b0) $display("FAIL sb_single_ack got=%b exp=0", ack2); else pass_cnt++;
    total_cnt++; if (sl !== 0) $display("FAIL sb_stall got=%0d low cycles exp=0", sl); else pass_cnt++;
  endtask

  task automatic test_lhu();
    logic [31:0] rd; int cyc, sl, rh; logic mis, ack2;
    data_txn(1'b0, 2'b01, 32'h202, 32'h0, 32'hBEEF1234, 0, rd, cyc, sl, rh, mis, ack2);
    total_cnt++; if (cap_be !== 4'b1100) $display("FAIL lhu_be got=%b exp=1100", cap_be); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0000BEEF) $display("FAIL lhu_rdata got=%h exp=0000beef", rd); else pass_cnt++;
    total_cnt++; if (cyc !== 3) $display("FAIL lhu_latency got=%0d exp=3", cyc); else pass_cnt++;
  endtask

  task automatic test_misalign();
    logic [31:0] rd; int cyc, sl, rh, n0; logic mis, ack2;
    n0 = bus_txns;
    data_txn(1'b0, 2'b00, 32'h101, 32'h0, 32'h11223344, 0, rd, cyc, sl, rh, mis, ack2);
`ifdef MISALIGN_TRAP_EN
    total_cnt++; if (cyc !== 1) $display("FAIL trap_latency got=%0d exp=1", cyc); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0) $display("FAIL trap_rdata got=%h exp=0", rd); else pass_cnt++;
    total_cnt++; if (mis !== 1'b1) $display("FAIL trap_err got=%b exp=1", mis); else pass_cnt++;
    total_cnt++; if (rh !== 0 || bus_txns !== n0) $display("FAIL trap_no_bus got=%0d req cycles exp=0", rh); else pass_cnt++;
`else
    total_cnt++; if (cyc !== 3) $display("FAIL unaligned_latency got=%0d exp=3", cyc); else pass_cnt++;
    total_cnt++; if (cap_addr !== 32'h100) $display("FAIL unaligned_addr got=%h exp=100", cap_addr); else pass_cnt++;
    total_cnt++; if (cap_be !== 4'hF) $display("FAIL unaligned_be got=%h exp=f", cap_be); else pass_cnt++;
    total_cnt++; if (rd !== 32'h11223344) $display("FAIL unaligned_rdata got=%h exp=11223344", rd); else pass_cnt++;
    total_cnt++; if (mis !== 1'b0) $display("FAIL unaligned_err got=%b exp=0", mis); else pass_cnt++;
    if (bus_txns != n0 + 1) begin total_cnt++; $display("FAIL unaligned_bus got=%0d txns exp=1", bus_txns - n0); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] rd, a, w, rdv; int cyc, sl, rh, lat; logic mis, ack2, we; logic [1:0] sz;
    for (int i = 0; i < 24; i++) begin
      lat = int'($urandom_range(0, 2));
      a = $urandom; w = $urandom; rdv = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        a[1:0] = 2'b00;
        fetch_txn(a, rdv, lat, rd, cyc);
        total_cnt++; if (cyc !== 3 + lat) $display("FAIL rnd_fetch_latency i=%0d got=%0d exp=%0d", i, cyc, 3 + lat); else pass_cnt++;
        total_cnt++; if (rd !== rdv) $display("FAIL rnd_fetch_rdata i=%0d got=%h exp=%h", i, rd, rdv); else pass_cnt++;
        total_cnt++; if (cap_addr !== a || cap_be !== 4'hF) $display("FAIL rnd_fetch_bus i=%0d got=%h/%h exp=%h/f", i, cap_addr, cap_be, a); else pass_cnt++;
      end else begin
        we = 1'($urandom_range(0, 1));
        sz = 2'($urandom_range(0, 3));
`ifdef MISALIGN_TRAP_EN
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz != 2'b10) a[1:0] = 2'b00;
`endif
        data_txn(we, sz, a, w, rdv, lat, rd, cyc, sl, rh, mis, ack2);
        total_cnt++; if (cyc !== 3 + lat) $display("FAIL rnd_data_latency i=%0d got=%0d exp=%0d", i, cyc, 3 + lat); else pass_cnt++;
        total_cnt++; if (rd !== ref_rdata(sz, a, rdv, we)) $display("FAIL rnd_data_rdata i=%0d got=%h exp=%h", i, rd, ref_rdata(sz, a, rdv, we)); else pass_cnt++;
        total_cnt++; if (cap_addr !== {a[31:2], 2'b00}) $display("FAIL rnd_data_addr i=%0d got=%h exp=%h", i, cap_addr, {a[31:2], 2'b00}); else pass_cnt++;
        total_cnt++; if (cap_be !== ref_be(sz, a)) $display("FAIL rnd_data_be i=%0d got=%h exp=%h", i, cap_be, ref_be(sz, a)); else pass_cnt++;
        total_cnt++; if (cap_we !== we) $display("FAIL rnd_data_we i=%0d got=%b exp=%b", i, cap_we, we); else pass_cnt++;
        if (we) begin
          total_cnt++; if (cap_wdata !== ref_wdata(sz, w)) $display("FAIL rnd_data_wdata i=%0d got=%h exp=%h", i, cap_wdata, ref_wdata(sz, w)); else pass_cnt++;
        end
        total_cnt++; if (sl !== 0 || ack2 !== 1'b0) $display("FAIL rnd_data_stall_ack i=%0d got=%0d/%b exp=0/0", i, sl, ack2); else pass_cnt++;
      end
    end
  endtask

  task automatic test_contention();
    int cyc, d_at, i_at, stall_low, n0; logic first_we;
    rd_val = 32'hCAFEF00D; mem_lat = 0; n0 = bus_txns;
    bus.d_we = 1'b1; bus.d_size = 2'b00; bus.d_addr = 32'h300; bus.d_wdata = 32'h55AA55AA;
    bus.if_addr = 32'h80;
    bus.d_req = 1'b1; bus.if_req = 1'b1;
    cyc = 0; d_at = 0; i_at = 0; stall_low = 0; first_we = 1'bx;
    while (i_at == 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.d_ack === 1'b1) begin d_at = cyc; bus.d_req = 1'b0; first_we = cap_we; end
      if (bus.if_ack === 1'b1) begin i_at = cyc; bus.if_req = 1'b0; end
      else if (bus.stall !== 1'b1) stall_low++;
    end
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (d_at !== 3) $display("FAIL cont_data_first got=%0d exp=3", d_at); else pass_cnt++;
    total_cnt++; if (i_at !== 7) $display("FAIL cont_fetch_next got=%0d exp=7", i_at); else pass_cnt++;
    total_cnt++; if (first_we !== 1'b1) $display("FAIL cont_first_is_store got=%b exp=1", first_we); else pass_cnt++;
    total_cnt++; if (stall_low !== 0) $display("FAIL cont_stall got=%0d low cycles exp=0", stall_low); else pass_cnt++;
    total_cnt++; if (bus_txns - n0 !== 2) $display("FAIL cont_bus_count got=%0d exp=2", bus_txns - n0); else pass_cnt++;
    total_cnt++; if (gap_viol !== 0) $display("FAIL cont_bus_gap got=%0d exp=0", gap_viol); else pass_cnt++;
  endtask

  task automatic test_stray_ack();
    logic [31:0] rd; int cyc;
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if ({bus.if_ack, bus.d_ack, bus.mem_req} !== 3'b000) $display("FAIL stray_ignored got=%b exp=000", {bus.if_ack, bus.d_ack, bus.mem_req}); else pass_cnt++;
    fetch_txn(32'h44, 32'h0BADF00D, 1, rd, cyc);
    total_cnt++; if (cyc !== 4 || rd !== 32'h0BADF00D) $display("FAIL stray_after got=%0d/%h exp=4/0badf00d", cyc, rd); else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic [31:0] rd; int cyc, sl, rh; logic mis, ack2;
    mem_en = 1'b0;
    data_txn(1'b0, 2'b00, 32'h400, 32'h0, 32'h0, 0, rd, cyc, sl, rh, mis, ack2);
    total_cnt++; if (rh !== TO) $display("FAIL to_req_cycles got=%0d exp=%0d", rh, TO); else pass_cnt++;
    total_cnt++; if (cyc !== TO + 1) $display("FAIL to_ack_cycle got=%0d exp=%0d", cyc, TO + 1); else pass_cnt++;
    total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL to_rdata got=%h exp=deadbeef", rd); else pass_cnt++;
    total_cnt++; if (bus.timeout_err !== 1'b1) $display("FAIL to_err_set got=%b exp=1", bus.timeout_err); else pass_cnt++;
    mem_en = 1'b1;
    fetch_txn(32'h48, 32'h01020304, 0, rd, cyc);
    total_cnt++; if (bus.timeout_err !== 1'b1) $display("FAIL to_err_sticky got=%b exp=1", bus.timeout_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int acks;
    mem_en = 1'b0;
    bus.d_we = 1'b0; bus.d_size = 2'b00; bus.d_addr = 32'h500; bus.d_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total_cnt++; if (bus.mem_req !== 1'b1) $display("FAIL rmid_in_grant got=%b exp=1", bus.mem_req); else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL rmid_mem_req got=%b exp=0", bus.mem_req); else pass_cnt++;
    total_cnt++; if (bus.timeout_err !== 1'b0) $display("FAIL rmid_err_clear got=%b exp=0", bus.timeout_err); else pass_cnt++;
    bus.d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_en = 1'b1;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.d_ack === 1'b1 || bus.mem_req === 1'b1) acks++;
    end
    total_cnt++; if (acks !== 0) $display("FAIL rmid_no_ack got=%0d exp=0", acks); else pass_cnt++;
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'b00; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_fetch();
    test_store_byte();
    test_lhu();
    test_misalign();
    test_random();
    test_contention();
    test_stray_ack();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
